mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: IM_LIMIT, 64'h1FFF, addresses strictly below this value decode to instruction memory.
REQ-002 Parameter: DM_AW, 13, data-memory address width.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports, per requester p in {cpu, dma}: p_req in 1; p_we in 1; p_addr in 64; p_wdata in 64; p_rdata out 64; p_ack out 1; p_err out 1.
REQ-006 Ports: dm_addr out DM_AW; dm_we out 1; dm_din out 64; dm_dout in 64 (combinational read).
REQ-007 Ports: im_addr out 64 (word address, byte address >> 2); im_data in 32 (combinational read).

Function
REQ-008 The block SHALL share the one unified memory space between two requesters using a three-state FSM: IDLE, ACCESS, RESP.
REQ-009 IDLE: if any req is high, latch the winner index, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-010 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; a single requester is granted regardless of history.
REQ-011 ACCESS lasts exactly one cycle; dm_addr = latched addr[DM_AW-1:0], im_addr = {2'b0, addr[63:2]}, dm_din = latched wdata.
REQ-012 dm_we SHALL be 1 only in ACCESS, only when latched we=1 and the address is >= IM_LIMIT; the write commits on the edge leaving ACCESS.
REQ-013 Reads: on the edge leaving ACCESS, capture {32'b0, im_data} for the IM region, else dm_dout, into a response register.
REQ-014 Writes to the IM region SHALL NOT reach memory; the transaction completes with err=1.
REQ-015 RESP: assert the granted port's ack for exactly one cycle, with rdata and err valid in that cycle; then return to IDLE.
REQ-016 Requesters SHALL hold req, we, addr and wdata stable from assertion through ack; the block samples them only in IDLE.
REQ-017 Latency SHALL be req seen in IDLE at edge N -> ack high during cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-018 A req still high in the cycle after ack is a new transaction, arbitrated normally in IDLE.
REQ-019 p_rdata and p_err SHALL hold their last value while ack is low; the non-granted port's ack SHALL stay 0.
REQ-020 Address IM_LIMIT-1 (0x1FFE) decodes to IM; IM_LIMIT (0x1FFF) decodes to DM; DM addresses wrap modulo 2^DM_AW.

Reset
REQ-021 While reset is high: state = IDLE; both acks = 0; both errs = 0; rdata registers = 0; dm_we = 0; last-grant = dma, so cpu wins the first tie.
REQ-022 Reset asserted during ACCESS SHALL suppress dm_we immediately (dm_we is decoded from state), so no write commits.
REQ-023 Reset asserted during RESP SHALL drop ack immediately; the transaction is lost and the requester reissues it.

Structure
REQ-024 A shared package mem_arbiter_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the port-index constants (PORT_CPU=0, PORT_DMA=1) and the default IM_LIMIT.
REQ-025 Grant selection SHALL live in one sub-module, rr_pick2 (inputs: req[1:0], last; output: grant index), which is purely combinational.
REQ-026 All outputs except dm_we, dm_addr, dm_din and im_addr SHALL be registered.

Verification
REQ-027 cpu read at 0x0008 with im_data=32'hDEADBEEF: cpu_ack high 2 cycles after req is seen, cpu_rdata = 64'h00000000DEADBEEF, cpu_err = 0.
REQ-028 dma write 64'h1122334455667788 to 0x2000, then cpu read of 0x2000: dm_we pulses once with dm_addr=0; the read returns 64'h1122334455667788.
REQ-029 cpu and dma both request from reset: cpu granted first, then dma; with both held high, grants alternate cpu, dma, cpu.
REQ-030 cpu write to 0x1FFE: dm_we never asserts; ack with err=1; a write to 0x1FFF asserts dm_we with err=0.
REQ-031 reset pulsed during ACCESS of a DM write: dm_we = 0 on that edge, memory unchanged, FSM in IDLE, no ack.
REQ-032 Single cpu request held high: acks at cycles 2, 5, 8, and dma_ack stays 0 throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg                                                      |
// | Shared FSM state type, requester indices and default IM boundary.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [63:0] c_IM_LIMIT_DEFAULT = 64'h1FFF;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2                                                             |
// | Two-way round-robin grant selection, purely combinational.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // A lone requester always wins; a tie goes to whoever did not win last.
    always_comb begin
        grant = PORT_CPU;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = PORT_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Shares unified instruction/data memory between cpu and dma ports.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [63:0] IM_LIMIT = c_IM_LIMIT_DEFAULT,
    parameter int          DM_AW    = 13
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [63:0]      cpu_addr,
    input  logic [63:0]      cpu_wdata,
    output logic [63:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic             cpu_err,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [63:0]      dma_addr,
    input  logic [63:0]      dma_wdata,
    output logic [63:0]      dma_rdata,
    output logic             dma_ack,
    output logic             dma_err,

    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic [63:0]      dm_din,
    input  logic [63:0]      dm_dout,

    output logic [63:0]      im_addr,
    input  logic [31:0]      im_data
);

    state_t      r_state;
    logic        r_port;
    logic        r_last;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic        w_grant;
    logic        w_is_im;
    logic        w_err;
    logic [63:0] w_rd;

    rr_pick2 u_pick (
        .req   ({dma_req, cpu_req}),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_is_im = (r_addr < IM_LIMIT);
    assign w_err   = r_we & w_is_im;
    assign w_rd    = w_is_im ? {32'b0, im_data} : dm_dout;

    // Decoded from state so an asynchronous reset kills a pending write at once.
    assign dm_we   = (r_state == ACCESS) & r_we & ~w_is_im;
    assign dm_addr = r_addr[DM_AW-1:0];
    assign dm_din  = r_wdata;
    assign im_addr = {2'b0, r_addr[63:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_port    <= PORT_CPU;
            r_last    <= PORT_DMA;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            dma_ack   <= 1'b0;
            dma_err   <= 1'b0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req | dma_req) begin
                        r_port  <= w_grant;
                        r_last  <= w_grant;
                        r_we    <= (w_grant == PORT_DMA) ? dma_we    : cpu_we;
                        r_addr  <= (w_grant == PORT_DMA) ? dma_addr  : cpu_addr;
                        r_wdata <= (w_grant == PORT_DMA) ? dma_wdata : cpu_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    // Write responses keep the previous read data on rdata.
                    if (r_port == PORT_CPU) begin
                        cpu_ack <= 1'b1;
                        cpu_err <= w_err;
                        if (!r_we) begin
                            cpu_rdata <= w_rd;
                        end
                    end else begin
                        dma_ack <= 1'b1;
                        dma_err <= w_err;
                        if (!r_we) begin
                            dma_rdata <= w_rd;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Self-checking bench: vector table, corner sequences, random model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

    typedef struct {
        logic        c_en;
        logic        c_we;
        logic [63:0] c_addr;
        logic [63:0] c_wdata;
        logic        d_en;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic        force_im;
        logic        first;
        logic [63:0] c_rd;
        logic        c_err;
        logic [63:0] d_rd;
        logic        d_err;
        int          n_wr;
        logic [12:0] wr_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_req   [2];
    logic        t_we    [2];
    logic [63:0] t_addr  [2];
    logic [63:0] t_wdata [2];

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [63:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [63:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [12:0] dm_addr;
    logic        dm_we;
    logic [63:0] dm_din, dm_dout;
    logic [63:0] im_addr;
    logic [31:0] im_data;
    logic        im_force;

    logic [63:0] dm_mem [0:8191];
    int          wr_count;
    logic [12:0] last_wr_addr;

    int          n_pass;
    int          n_total;

    logic [63:0] ref_mem [int];
    logic [63:0] exp_rd  [2];
    logic        model_last;

    assign cpu_req   = t_req[0];
    assign cpu_we    = t_we[0];
    assign cpu_addr  = t_addr[0];
    assign cpu_wdata = t_wdata[0];
    assign dma_req   = t_req[1];
    assign dma_we    = t_we[1];
    assign dma_addr  = t_addr[1];
    assign dma_wdata = t_wdata[1];

    function automatic logic [31:0] im_fn(input logic [63:0] w);
        return w[31:0] * 32'h9E3779B1 + w[63:32] + 32'h01234567;
    endfunction

    assign im_data = im_force ? 32'hDEADBEEF : im_fn(im_addr);
    assign dm_dout = dm_mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) dm_mem[dm_addr] = dm_din;
    end

    always @(negedge clk) begin
        if (dm_we) begin
            wr_count     = wr_count + 1;
            last_wr_addr = dm_addr;
        end
    end

    always #5 clk = ~clk;

    mem_arbiter #(.IM_LIMIT(64'h1FFF), .DM_AW(13)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .dma_err   (dma_err),
        .dm_addr   (dm_addr),
        .dm_we     (dm_we),
        .dm_din    (dm_din),
        .dm_dout   (dm_dout),
        .im_addr   (im_addr),
        .im_data   (im_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) dm_mem[i] = 64'h0;
        ref_mem.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = 64'h0; t_wdata[i] = 64'h0;
        end
        im_force = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one round (one or two requesters) and checks order, latency and responses.
    task automatic run_round(input vec_t v, input string tag);
        int nreq;
        int base;
        @(negedge clk);
        t_req[0] = v.c_en; t_we[0] = v.c_we; t_addr[0] = v.c_addr; t_wdata[0] = v.c_wdata;
        t_req[1] = v.d_en; t_we[1] = v.d_we; t_addr[1] = v.d_addr; t_wdata[1] = v.d_wdata;
        im_force = v.force_im;
        base = wr_count;
        nreq = int'(v.c_en) + int'(v.d_en);
        for (int k = 0; k < nreq; k++) begin
            int  p;
            int  cyc;
            logic hit;
            p   = (k == 0) ? int'(v.first) : int'(!v.first);
            cyc = 0;
            hit = 1'b0;
            while (!hit && cyc < 8) begin
                @(negedge clk);
                cyc++;
                if (cpu_ack | dma_ack) hit = 1'b1;
            end
            check($sformatf("%s latency%0d", tag, k), 64'(cyc), (k == 0) ? 64'd2 : 64'd3);
            check($sformatf("%s ack%0d", tag, k), {62'b0, dma_ack, cpu_ack}, (p == 1) ? 64'd2 : 64'd1);
            if (p == 0) begin
                check($sformatf("%s cpu_rdata", tag), cpu_rdata, v.c_rd);
                check($sformatf("%s cpu_err", tag), {63'b0, cpu_err}, {63'b0, v.c_err});
            end else begin
                check($sformatf("%s dma_rdata", tag), dma_rdata, v.d_rd);
                check($sformatf("%s dma_err", tag), {63'b0, dma_err}, {63'b0, v.d_err});
            end
            t_req[p] = 1'b0;
        end
        @(negedge clk);
        im_force = 1'b0;
        check($sformatf("%s acks_low", tag), {62'b0, dma_ack, cpu_ack}, 64'd0);
        if (v.c_en) check($sformatf("%s cpu_rdata_hold", tag), cpu_rdata, v.c_rd);
        if (v.d_en) check($sformatf("%s dma_rdata_hold", tag), dma_rdata, v.d_rd);
        check($sformatf("%s dm_we_pulses", tag), 64'(wr_count - base), 64'(v.n_wr));
        if (v.n_wr > 0) check($sformatf("%s dm_addr", tag), {51'b0, last_wr_addr}, {51'b0, v.wr_addr});
    endtask

    // Holds requests for nine cycles; acks expected on cycles 2, 5 and 8.
    task automatic hold_seq(input logic both, input string tag);
        @(negedge clk);
        t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 64'h2000;
        t_req[1] = both; t_we[1] = 1'b0; t_addr[1] = 64'h2008;
        for (int c = 1; c <= 9; c++) begin
            logic [1:0] exp;
            @(negedge clk);
            exp = 2'b00;
            if (c == 2 || c == 8) exp = 2'b01;
            else if (c == 5) exp = both ? 2'b10 : 2'b01;
            check($sformatf("%s cyc%0d acks", tag, c), {62'b0, dma_ack, cpu_ack}, {62'b0, exp});
        end
        t_req[0] = 1'b0;
        t_req[1] = 1'b0;
    endtask

    function automatic void model_txn(input int p, input logic we, input logic [63:0] a,
                                      input logic [63:0] wd, output logic err, output logic wrote);
        int   k;
        logic im;
        k     = int'(a[12:0]);
        im    = (a < 64'h1FFF);
        err   = we & im;
        wrote = we & ~im;
        if (wrote) ref_mem[k] = wd;
        else if (!we) exp_rd[p] = im ? {32'h0, im_fn(a >> 2)} : (ref_mem.exists(k) ? ref_mem[k] : 64'h0);
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 64'h1FF8 + 64'($urandom_range(0, 15));
            1:       return 64'($urandom_range(0, 32'h1FFE));
            2:       return 64'h2000 + 64'($urandom_range(0, 63));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        vec_t v;
        n_pass   = 0;
        n_total  = 0;
        wr_count = 0;
        last_wr_addr = 13'h0;
        clear_mem();
        reset = 1'b1;
        im_force = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = 64'h0; t_wdata[i] = 64'h0;
        end
        @(negedge clk);
        check("reset cpu_ack", {63'b0, cpu_ack}, 64'd0);
        check("reset dma_ack", {63'b0, dma_ack}, 64'd0);
        check("reset errs", {62'b0, dma_err, cpu_err}, 64'd0);
        check("reset cpu_rdata", cpu_rdata, 64'd0);
        check("reset dma_rdata", dma_rdata, 64'd0);
        check("reset dm_we", {63'b0, dm_we}, 64'd0);
        do_reset();

        vecs[0] = '{1'b1, 1'b0, 64'h8,    64'h0,                 1'b0, 1'b0, 64'h0,    64'h0,
                    1'b1, 1'b0, 64'h00000000DEADBEEF, 1'b0, 64'h0, 1'b0, 0, 13'h0};
        vecs[1] = '{1'b0, 1'b0, 64'h0,    64'h0,                 1'b1, 1'b1, 64'h2000, 64'h1122334455667788,
                    1'b0, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0, 1, 13'h0};
        vecs[2] = '{1'b1, 1'b0, 64'h2000, 64'h0,                 1'b0, 1'b0, 64'h0,    64'h0,
                    1'b0, 1'b0, 64'h1122334455667788, 1'b0, 64'h0, 1'b0, 0, 13'h0};
        vecs[3] = '{1'b1, 1'b1, 64'h1FFE, 64'hFFFFFFFFFFFFFFFF,  1'b0, 1'b0, 64'h0,    64'h0,
                    1'b0, 1'b0, 64'h1122334455667788, 1'b1, 64'h0, 1'b0, 0, 13'h0};
        vecs[4] = '{1'b1, 1'b1, 64'h1FFF, 64'hAAAAAAAAAAAAAAAA,  1'b0, 1'b0, 64'h0,    64'h0,
                    1'b0, 1'b0, 64'h1122334455667788, 1'b0, 64'h0, 1'b0, 1, 13'h1FFF};
        vecs[5] = '{1'b1, 1'b0, 64'h1FFF, 64'h0,                 1'b1, 1'b0, 64'h3FFF, 64'h0,
                    1'b0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 0, 13'h0};
        vecs[6] = '{1'b1, 1'b0, 64'h2008, 64'h0,                 1'b1, 1'b1, 64'h2008, 64'h0123456789ABCDEF,
                    1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1, 13'h0008};
        vecs[7] = '{1'b1, 1'b0, 64'h1FFE, 64'h0,                 1'b0, 1'b0, 64'h0,    64'h0,
                    1'b0, 1'b0, {32'h0, im_fn(64'h7FF)}, 1'b0, 64'h0, 1'b0, 0, 13'h0};
        for (int i = 0; i < 8; i++) run_round(vecs[i], $sformatf("vec%0d", i));

        do_reset();
        hold_seq(1'b1, "alternate");
        hold_seq(1'b0, "cpu_hold");

        // Reset landing in ACCESS of a DM write must leave memory untouched.
        do_reset();
        dm_mem[16] = 64'h5555555555555555;
        begin
            int base;
            base = wr_count;
            @(negedge clk);
            t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 64'h2010; t_wdata[1] = 64'hFACEFACEFACEFACE;
            @(posedge clk);
            #2;
            check("rst_access dm_we_before", {63'b0, dm_we}, 64'd1);
            reset = 1'b1;
            #1;
            check("rst_access dm_we_after", {63'b0, dm_we}, 64'd0);
            @(negedge clk);
            check("rst_access mem", dm_mem[16], 64'h5555555555555555);
            check("rst_access acks", {62'b0, dma_ack, cpu_ack}, 64'd0);
            check("rst_access pulses", 64'(wr_count - base), 64'd0);
            t_req[1] = 1'b0;
            reset = 1'b0;
        end
        v = '{1'b1, 1'b0, 64'h2010, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0,
              1'b0, 1'b0, 64'h5555555555555555, 1'b0, 64'h0, 1'b0, 0, 13'h0};
        run_round(v, "post_rst");

        // Reset landing in RESP drops the ack immediately.
        begin
            int   cyc;
            logic hit;
            @(negedge clk);
            t_req[1] = 1'b1; t_we[1] = 1'b0; t_addr[1] = 64'h2010;
            cyc = 0;
            hit = 1'b0;
            while (!hit && cyc < 8) begin
                @(negedge clk);
                cyc++;
                if (dma_ack) hit = 1'b1;
            end
            check("rst_resp ack_seen", {63'b0, hit}, 64'd1);
            #1;
            reset = 1'b1;
            #1;
            check("rst_resp ack_dropped", {63'b0, dma_ack}, 64'd0);
            @(negedge clk);
            t_req[1] = 1'b0;
            reset = 1'b0;
        end

        do_reset();
        clear_mem();
        exp_rd[0] = 64'h0;
        exp_rd[1] = 64'h0;
        model_last = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int mode;
            mode       = int'($urandom_range(0, 2));
            v.c_en     = (mode != 1);
            v.d_en     = (mode != 0);
            v.c_we     = 1'($urandom_range(0, 1));
            v.d_we     = 1'($urandom_range(0, 1));
            v.c_addr   = rand_addr();
            v.d_addr   = rand_addr();
            v.c_wdata  = {$urandom, $urandom};
            v.d_wdata  = {$urandom, $urandom};
            v.force_im = 1'b0;
            v.first    = (v.c_en && v.d_en) ? ~model_last : v.d_en;
            v.n_wr     = 0;
            v.wr_addr  = 13'h0;
            v.c_err    = 1'b0;
            v.d_err    = 1'b0;
            for (int k = 0; k < 2; k++) begin
                int   p;
                logic err, wrote;
                p = (k == 0) ? int'(v.first) : int'(!v.first);
                if ((p == 0 && v.c_en) || (p == 1 && v.d_en)) begin
                    if (p == 0) model_txn(0, v.c_we, v.c_addr, v.c_wdata, err, wrote);
                    else        model_txn(1, v.d_we, v.d_addr, v.d_wdata, err, wrote);
                    if (wrote) begin
                        v.n_wr++;
                        v.wr_addr = (p == 0) ? v.c_addr[12:0] : v.d_addr[12:0];
                    end
                    if (p == 0) v.c_err = err;
                    else        v.d_err = err;
                    model_last = (p == 1);
                end
            end
            v.c_rd = exp_rd[0];
            v.d_rd = exp_rd[1];
            run_round(v, $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
